// File: rtl/muxn_rr.sv
// muxn_rr: N-channel registered multiplexer with a valid/ready output stage.
// Candidate selection is either manual (sel_in) or round-robin from the
// pointer. The pointer starts at CHANNELS-1, so channel 0 is granted first.
// Optional feature macro: MUXN_RR_LOCK_EN adds a `lock` input. While lock is
// high in round-robin mode, only channel ptr may be granted.
module muxn_rr #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] din,
`ifdef MUXN_RR_LOCK_EN
  input  logic                      lock,
`endif
  output logic [CHANNELS-1:0]       grant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_data;
  logic [SEL_W-1:0]   r_ch;
  logic [SEL_W-1:0]   r_ptr;

  logic               w_load;
  logic               w_lock_hold;
  logic               w_man_ok;
  logic               w_rr_found;
  logic [SEL_W-1:0]   w_rr_idx;
  logic               w_cand_found;
  logic [SEL_W-1:0]   w_cand_idx;
  logic               w_capture;
  logic [WIDTH-1:0]   w_words [CHANNELS];

`ifdef MUXN_RR_LOCK_EN
  assign w_lock_hold = mode & lock;
`else
  assign w_lock_hold = 1'b0;
`endif

  // Unpack the flat input bus into per-channel words.
  always_comb begin
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      w_words[k] = din[k*WIDTH +: WIDTH];
    end
  end

  // The output register may take a new word when empty or being drained.
  always_comb begin
    w_load = (r_state == ST_EMPTY) || out_ready;
  end

  // Manual candidate: sel_in must be in range and requesting.
  always_comb begin
    w_man_ok = 1'b0;
    if (32'(sel_in) < CHANNELS) begin
      w_man_ok = req[sel_in];
    end
  end

  // Round-robin search from ptr+1 upward, wrapping, ending on ptr itself.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int unsigned off = 1; off <= CHANNELS; off++) begin
      logic [SEL_W-1:0] idx;
      idx = SEL_W'((32'(r_ptr) + off) % CHANNELS);
      if (!w_rr_found && req[idx]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = idx;
      end
    end
  end

  // Choose the candidate for this cycle according to mode and lock.
  always_comb begin
    w_cand_found = 1'b0;
    w_cand_idx   = '0;
    if (w_lock_hold) begin
      w_cand_found = req[r_ptr];
      w_cand_idx   = r_ptr;
    end else if (mode) begin
      w_cand_found = w_rr_found;
      w_cand_idx   = w_rr_idx;
    end else begin
      w_cand_found = w_man_ok;
      w_cand_idx   = sel_in;
    end
  end

  // A capture needs both a free or draining slot and a candidate.
  always_comb begin
    w_capture = w_load && w_cand_found;
  end

  // State register for the output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: refill on capture, drain when loaded without a candidate.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = w_capture ? ST_FULL : ST_EMPTY;
    end
  end

  // Output decode: valid follows the slot state, grant is one-hot on capture.
  always_comb begin
    out_valid = (r_state == ST_FULL);
    grant     = '0;
    if (w_capture) begin
      grant[w_cand_idx] = 1'b1;
    end
  end

  // Data path and round-robin pointer; they hold when nothing is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_ch   <= '0;
      r_ptr  <= SEL_W'(CHANNELS - 1);
    end else if (w_capture) begin
      r_data <= w_words[w_cand_idx];
      r_ch   <= w_cand_idx;
      if (mode) begin
        r_ptr <= w_cand_idx;
      end
    end
  end

  assign out_data = r_data;
  assign out_ch   = r_ch;

endmodule

// File: tb/tb_muxn_rr.sv
// Directed testbench for muxn_rr (WIDTH=8, CHANNELS=4, SEL_W=2).
// Each task is entered just after a falling edge and leaves on a falling edge.
// Combinational grant is sampled 1ns after inputs change, and registered
// outputs are sampled 1ns after the rising edge.
module tb_muxn_rr;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned SEL_W    = 2;

  logic                      clk;
  logic                      rst_n;
  logic                      mode;
  logic [SEL_W-1:0]          sel_in;
  logic [CHANNELS-1:0]       req;
  logic [CHANNELS*WIDTH-1:0] din;
`ifdef MUXN_RR_LOCK_EN
  logic                      lock;
`endif
  logic [CHANNELS-1:0]       grant;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_ch;

  int n_checks;
  int n_fail;

  // word0=11 word1=22 word2=A5 word3=44
  localparam logic [CHANNELS*WIDTH-1:0] DIN = {8'h44, 8'hA5, 8'h22, 8'h11};

  muxn_rr #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .SEL_W   (SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .sel_in   (sel_in),
    .req      (req),
    .din      (din),
`ifdef MUXN_RR_LOCK_EN
    .lock     (lock),
`endif
    .grant    (grant),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ch   (out_ch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel_in    = '0;
    req       = '0;
    din       = DIN;
    out_ready = 1'b1;
`ifdef MUXN_RR_LOCK_EN
    lock      = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 0", i, out_valid);
      end
      n_checks++;
      if (out_data !== 8'h00) begin
        n_fail++; $display("FAIL reset_data[%0d]: got %h expected 00", i, out_data);
      end
      n_checks++;
      if (out_ch !== 2'd0) begin
        n_fail++; $display("FAIL reset_ch[%0d]: got %0d expected 0", i, out_ch);
      end
      n_checks++;
      if (grant !== 4'b0000) begin
        n_fail++; $display("FAIL reset_grant[%0d]: got %b expected 0000", i, grant);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_manual();
    mode = 1'b0; sel_in = 2'd2; req = 4'b0100; out_ready = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++; $display("FAIL manual_grant: got %b expected 0100", grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL manual_valid: got %b expected 1", out_valid);
    end
    n_checks++;
    if (out_data !== 8'hA5) begin
      n_fail++; $display("FAIL manual_data: got %h expected a5", out_data);
    end
    n_checks++;
    if (out_ch !== 2'd2) begin
      n_fail++; $display("FAIL manual_ch: got %0d expected 2", out_ch);
    end
    @(negedge clk);
    sel_in = 2'd3;
    #1;
    n_checks++;
    if (grant !== 4'b0000) begin
      n_fail++; $display("FAIL manual_nogrant: got %b expected 0000", grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL manual_drain_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (out_data !== 8'hA5 || out_ch !== 2'd2) begin
      n_fail++; $display("FAIL manual_hold: got %h/%0d expected a5/2", out_data, out_ch);
    end
    @(negedge clk);
  endtask

  task automatic test_rr_fairness();
    logic [1:0] exp_ch [5];
    logic [7:0] exp_dat [5];
    exp_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_dat = '{8'h11, 8'h22, 8'hA5, 8'h44, 8'h11};
    mode = 1'b1; req = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (grant !== (4'b0001 << exp_ch[i])) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b expected ch%0d", i, grant, exp_ch[i]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_ch[i] || out_data !== exp_dat[i]) begin
        n_fail++;
        $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 i, out_valid, out_ch, out_data, exp_ch[i], exp_dat[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_pressure();
    req = 4'b0010; out_ready = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++; $display("FAIL bp_setup_grant: got %b expected 0010", grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_ch !== 2'd1 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_setup_out: got ch=%0d v=%b expected ch=1 v=1", out_ch, out_valid);
    end
    @(negedge clk);
    out_ready = 1'b0; req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (grant !== 4'b0000) begin
        n_fail++; $display("FAIL bp_stall_grant[%0d]: got %b expected 0000", i, grant);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h22) begin
        n_fail++;
        $display("FAIL bp_stall_hold[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=1 d=22",
                 i, out_valid, out_ch, out_data);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++; $display("FAIL bp_release_grant: got %b expected 0100", grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL bp_release_out: got v=%b ch=%0d d=%h expected v=1 ch=2 d=a5",
               out_valid, out_ch, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; req = 4'b0000;
    #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre_valid: got %b expected 1", out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (out_data !== 8'h00 || out_ch !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_regs: got d=%h ch=%0d expected d=00 ch=0", out_data, out_ch);
    end
    @(negedge clk);
    rst_n = 1'b1; mode = 1'b1; req = 4'b1001; out_ready = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_first_grant: got %b expected 0001", grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin
      n_fail++;
      $display("FAIL rstmid_first_out: got v=%b ch=%0d d=%h expected v=1 ch=0 d=11",
               out_valid, out_ch, out_data);
    end
    @(negedge clk);
  endtask

`ifdef MUXN_RR_LOCK_EN
  task automatic test_lock();
    mode = 1'b1; lock = 1'b0; req = 4'b0100; out_ready = 1'b1;
    #1;
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++; $display("FAIL lock_setup_grant: got %b expected 0100", grant);
    end
    @(posedge clk);
    @(negedge clk);
    lock = 1'b1; req = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (grant !== 4'b0100) begin
        n_fail++; $display("FAIL lock_hold_grant[%0d]: got %b expected 0100", i, grant);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_ch !== 2'd2) begin
        n_fail++; $display("FAIL lock_hold_ch[%0d]: got %0d expected 2", i, out_ch);
      end
      @(negedge clk);
    end
    lock = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b1000) begin
      n_fail++; $display("FAIL lock_release_grant: got %b expected 1000", grant);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_ch !== 2'd3 || out_data !== 8'h44) begin
      n_fail++; $display("FAIL lock_release_out: got ch=%0d d=%h expected ch=3 d=44", out_ch, out_data);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_manual();
    test_rr_fairness();
    test_back_pressure();
    test_reset_mid();
`ifdef MUXN_RR_LOCK_EN
    test_lock();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muxn_rr.md
# muxn_rr

Parametrised N-channel, WIDTH-bit registered multiplexer with a valid/ready output stage and two selection modes: manual (external select) and round-robin (fair scan over requesting channels). It is the sequential, generalised successor of the fixed 4:1 combinational mux. It sits between several producer channels and a single consumer that may stall.

## Interface
- WIDTH, 8, data bits per channel
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, select/channel-index width; must equal ceil(log2(CHANNELS))
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = manual select, 1 = round-robin
- sel_in  input  SEL_W  channel index used in manual mode
- req  input  CHANNELS  per-channel request; bit k means din word k is valid
- din  input  CHANNELS*WIDTH  flat input bus; channel k occupies bits [k*WIDTH +: WIDTH]
- grant  output  CHANNELS  combinational one-hot; bit k high in the cycle channel k's word is captured
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- out_data  output  WIDTH  captured word
- out_ch  output  SEL_W  index of the channel out_data came from

## Operation
- State: the output register is EMPTY (out_valid=0) or FULL (out_valid=1). The round-robin pointer ptr has width SEL_W.
- load = !out_valid || out_ready. Capture happens only when load is high and a candidate exists.
- Manual mode candidate: channel sel_in, if req[sel_in]=1 and sel_in < CHANNELS. An out-of-range sel_in never grants.
- Round-robin candidate: the first channel with req set, searching ptr+1, ptr+2, … wrapping modulo CHANNELS, ending at ptr itself. A lone requester is therefore re-granted every cycle.
- On capture of channel k:
  - grant[k]=1 in that cycle.
  - Next edge: out_data←din[k], out_ch←k, out_valid←1.
  - In round-robin mode, ptr←k. Manual mode never moves ptr.
- When load is high and there is no candidate, out_valid←0 at the next edge if the word was consumed. out_data and out_ch hold their last values.
- When FULL and out_ready=0, nothing is captured, grant=0, and outputs hold stable.
- Producers must keep req and din stable until granted.
- A mode change takes effect for the next candidate evaluation. It never disturbs a held word.
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=CHANNELS-1 (so channel 0 wins first), grant=0.

## Timing
- Latency is 1 cycle from grant to out_valid/out_data.
- Full throughput: one word per cycle when out_ready is held high.
- grant is a combinational function of req, mode, sel_in, ptr, out_valid and out_ready. There is no combinational path from din to any output.
- Accept and capture in the same cycle (FULL, out_ready=1, candidate present): the old word is consumed and the new word is loaded at the same edge, so out_valid stays 1.
- Reset asserted mid-transfer clears out_valid immediately (asynchronously). Any word in the register is dropped and ptr returns to CHANNELS-1.
- Reset deassertion must be synchronous to clk externally. The first capture is possible at the first edge after release.

## Configuration
- MUXN_RR_LOCK_EN defined:
  - Adds input port lock (1 bit).
  - While lock=1 in round-robin mode, the candidate is restricted to channel ptr (burst hold), and ptr does not advance.
  - If req[ptr]=0, nothing is granted.
  - lock is ignored in manual mode.
- MUXN_RR_LOCK_EN undefined: the lock port does not exist, and the round-robin search always proceeds as described above.

## Test plan
- Reset then idle: rst_n low then high with req=0. Expect out_valid=0, out_data=0, out_ch=0, grant=0 for 5 cycles.
- Manual select, CHANNELS=4, WIDTH=8, mode=0, sel_in=2, req=4'b0100, din word2=8'hA5, out_ready=1. Expect grant=4'b0100, then next cycle out_valid=1, out_data=8'hA5, out_ch=2. With sel_in=3 and req[3]=0, expect no grant.
- Round-robin fairness: mode=1, req=4'b1111, out_ready=1. Grants must follow channel order 0,1,2,3,0 on consecutive cycles, with out_ch trailing grant by 1 cycle.
- Back-pressure: FULL with out_ch=1 and out_ready=0 for 3 cycles. Expect grant=0 and out_data/out_ch unchanged. Then out_ready=1 with req=4'b0100: expect capture of ch2 at the same edge that consumes ch1, with out_valid never dropping.
- Reset mid-operation: assert rst_n low while FULL. Expect out_valid=0 without a clock edge. After release with req=4'b1001, the first grant is ch0.
- MUXN_RR_LOCK_EN: after ptr=2, set lock=1 and req=4'b1101. Expect grant=4'b0100 repeated while lock is held. Drop lock: next grant is ch3.
